// File: rtl/cr_prefix_strip.sv
// -----------------------------------------------------------------------------
// cr_prefix_strip
//
// Receive-side prefix removal for the AXI4-S TLV datapath.
// Inspects the header beat (SOT) of every TLV. A TLV whose type matches
// PREFIX_TLV_TYPE is dropped beat by beat while stripping is enabled. Every
// other TLV is forwarded bit-exact through a 2-entry skid buffer. Each TLV's
// beat count is checked against the word count in its header. Stat and error
// events are reported as registered single-cycle pulses.
//
// Ports
//   clk               clock
//   rst               synchronous, active-high reset
//   strip_ib_in       upstream beat (tuser[0] = SOT, tlast = end of TLV)
//   strip_ib_out      upstream tready; registered, equals skid occupancy < 2
//   strip_ob_in       downstream tready
//   strip_ob_out      downstream beat (head of the skid buffer, zero when empty)
//   cfg_strip_en      strip enable, sampled only on an accepted SOT beat
//   strip_stat_events [0] prefix stripped, [1] length error,
//                     [2] SOT protocol error
// -----------------------------------------------------------------------------

package cr_prefix_strip_pkg;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [0:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

endpackage

module cr_prefix_strip
  import cr_prefix_strip_pkg::*;
#(
  parameter logic [7:0]  PREFIX_TLV_TYPE = 8'd9,
  parameter int unsigned LEN_W           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  axi4s_dp_bus_t strip_ib_in,
  output axi4s_dp_rdy_t strip_ib_out,
  input  axi4s_dp_rdy_t strip_ob_in,
  output axi4s_dp_bus_t strip_ob_out,
  input  logic          cfg_strip_en,
  output logic [2:0]    strip_stat_events
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;

  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   w_cnt_next;
  logic [LEN_W-1:0]   w_cnt_inc;
  logic [LEN_W-1:0]   r_exp_cnt;
  logic [LEN_W-1:0]   w_exp_cnt_next;
  logic               r_chk_en;
  logic               w_chk_en_next;

  logic [2:0]         r_events;
  logic [2:0]         w_events_next;

  logic               w_accept;
  logic               w_sot;
  logic               w_new_tlv;
  logic               w_strip_hdr;
  logic [LEN_W-1:0]   w_hdr_cnt;
  logic               w_push;
  logic               w_pop;

  axi4s_dp_bus_t      r_skid_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_occ;
  logic [1:0]         w_occ_next;
  logic               r_ib_ready;

  // ---------------------------------------------------------------------------
  // Beat decode
  // ---------------------------------------------------------------------------
  assign w_accept  = strip_ib_in.tvalid & r_ib_ready;
  assign w_sot     = strip_ib_in.tuser[0];
  assign w_hdr_cnt = strip_ib_in.tdata[16+LEN_W-1:16];

  // A beat opens a new TLV when it is an SOT, or when it arrives while no TLV
  // is open. The second case is a protocol error, but the beat is still
  // forwarded so that no data is lost silently.
  assign w_new_tlv = (r_state == ST_IDLE) | w_sot;

  // The strip decision is made once, on the header beat. Later changes of
  // cfg_strip_en cannot affect a TLV that is already in flight.
  assign w_strip_hdr = w_sot & (strip_ib_in.tdata[7:0] == PREFIX_TLV_TYPE) & cfg_strip_en;

  // The counter saturates instead of wrapping. An oversized TLV therefore
  // cannot alias back onto a small header count.
  assign w_cnt_inc = (r_cnt == {LEN_W{1'b1}}) ? r_cnt : r_cnt + LEN_W'(1);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state, push decision and event generation
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_exp_cnt_next = r_exp_cnt;
    w_chk_en_next  = r_chk_en;
    w_push         = 1'b0;
    w_events_next  = 3'b000;

    if (w_accept) begin
      if (w_new_tlv) begin
        // An SOT that interrupts an open TLV, or a headerless beat in IDLE.
        // The interrupted TLV is abandoned without a length check.
        w_events_next[2] = ~w_sot | (r_state != ST_IDLE);
        w_cnt_next       = LEN_W'(1);
        w_exp_cnt_next   = w_sot ? w_hdr_cnt : '0;
        // A TLV without a header has no count to check against.
        w_chk_en_next    = w_sot;
        w_push           = ~w_strip_hdr;
        if (strip_ib_in.tlast) begin
          w_state_next     = ST_IDLE;
          w_events_next[1] = w_sot & (w_hdr_cnt != LEN_W'(1));
          // A single-beat prefix still counts as a stripped prefix.
          w_events_next[0] = w_strip_hdr;
        end else begin
          w_state_next = w_strip_hdr ? ST_DROP : ST_PASS;
        end
      end else begin
        w_cnt_next = w_cnt_inc;
        unique case (r_state)
          ST_PASS: w_push = 1'b1;
          ST_DROP: w_push = 1'b0;
          default: w_push = 1'b0;
        endcase
        if (strip_ib_in.tlast) begin
          w_state_next     = ST_IDLE;
          w_events_next[1] = r_chk_en & (w_cnt_inc != r_exp_cnt);
          w_events_next[0] = (r_state == ST_DROP);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Length tracking and event registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_exp_cnt <= '0;
      r_chk_en  <= 1'b0;
      r_events  <= 3'b000;
    end else begin
      r_cnt     <= w_cnt_next;
      r_exp_cnt <= w_exp_cnt_next;
      r_chk_en  <= w_chk_en_next;
      r_events  <= w_events_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  assign w_pop = (r_occ != 2'd0) & strip_ob_in.tready;

  always_comb begin
    w_occ_next = r_occ;
    unique case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + 2'd1;
      2'b01:   w_occ_next = r_occ - 2'd1;
      default: w_occ_next = r_occ;
    endcase
  end

  // The data entries need no reset. The output is masked to zero while the
  // buffer is empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_skid_mem[r_wr_ptr] <= strip_ib_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_ib_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ      <= w_occ_next;
      // Ready is computed from the next occupancy. It therefore tracks
      // (occupancy < 2) exactly, with no combinational path from the input.
      r_ib_ready <= (w_occ_next != 2'd2);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign strip_ib_out.tready = r_ib_ready;
  assign strip_ob_out        = (r_occ != 2'd0) ? r_skid_mem[r_rd_ptr] : '0;
  assign strip_stat_events   = r_events;

endmodule

// File: tb/tb_cr_prefix_strip.sv
// -----------------------------------------------------------------------------
// Testbench for cr_prefix_strip.
// The stimulus is a list of TLVs. Expected outputs and events are derived per
// TLV from its description: whether it has a header, whether it is a prefix,
// whether it ends with tlast, and its header count against its beat count.
// -----------------------------------------------------------------------------
module tb_cr_prefix_strip;
  import cr_prefix_strip_pkg::*;

  localparam logic [7:0] PTYPE = 8'd9;

  typedef struct {
    axi4s_dp_bus_t bus;
    bit            first;
    bit            hdr_sot;
    bit            is_ptype;
    bit            ev2;
    bit            lerr;
  } stim_t;

  logic          clk = 1'b0;
  logic          rst;
  axi4s_dp_bus_t ib_in;
  axi4s_dp_rdy_t ib_out;
  axi4s_dp_rdy_t ob_in;
  axi4s_dp_bus_t ob_out;
  logic          cfg_en;
  logic [2:0]    events;

  always #5 clk = ~clk;

  cr_prefix_strip dut (
    .clk               (clk),
    .rst               (rst),
    .strip_ib_in       (ib_in),
    .strip_ib_out      (ib_out),
    .strip_ob_in       (ob_in),
    .strip_ob_out      (ob_out),
    .cfg_strip_en      (cfg_en),
    .strip_stat_events (events)
  );

  int            total = 0;
  int            bad   = 0;
  int            n_out = 0;
  stim_t         stim[$];
  int            si = 0;
  bit            last_term = 1'b1;
  bit            cur_drop  = 1'b0;
  axi4s_dp_bus_t exp_out[$];
  logic [2:0]    ev_exp = 3'b000;

  // Append one TLV of n beats to the stimulus list.
  task automatic add_tlv(input bit sot, input logic [7:0] typ, input int hdr,
                         input int n, input bit term);
    stim_t s;
    for (int b = 0; b < n; b++) begin
      s.bus.tvalid = 1'b1;
      s.bus.tlast  = term && (b == n - 1);
      s.bus.tid    = 1'($urandom);
      s.bus.tstrb  = 8'($urandom);
      s.bus.tuser  = {7'($urandom), (b == 0) ? sot : 1'b0};
      s.bus.tdata  = {$urandom, $urandom};
      if (b == 0) begin
        s.bus.tdata[7:0]   = typ;
        s.bus.tdata[31:16] = 16'(hdr);
      end
      s.first    = (b == 0);
      s.hdr_sot  = sot;
      s.is_ptype = (typ == PTYPE);
      s.ev2      = (b == 0) && (!sot || !last_term);
      s.lerr     = sot && term && (b == n - 1) && (n != hdr);
      stim.push_back(s);
    end
    last_term = term;
  endtask

  // One clock cycle. Outputs are checked at the negedge, then new inputs are
  // driven for the next posedge.
  // vmode/rmode: 0 = off, 1 = on, 2 = random.
  // cmode: 0/1 = forced, 2 = random, 3 = toggle every cycle.
  task automatic cycle(input int vmode, input int rmode, input int cmode);
    bit    v;
    bit    r;
    stim_t s;
    @(negedge clk);
    total++;
    assert (events === ev_exp)
      else begin bad++; $error("FAIL events obs=%b exp=%b", events, ev_exp); end
    total++;
    assert (ob_out.tvalid === (exp_out.size() != 0))
      else begin bad++; $error("FAIL ob_tvalid obs=%b exp=%b", ob_out.tvalid, exp_out.size() != 0); end

    v = (vmode == 1) || (vmode == 2 && $urandom_range(0, 9) < 8);
    r = (rmode == 1) || (rmode == 2 && $urandom_range(0, 9) < 7);
    case (cmode)
      0:       cfg_en = 1'b0;
      1:       cfg_en = 1'b1;
      2:       cfg_en = 1'($urandom);
      default: cfg_en = ~cfg_en;
    endcase
    ob_in.tready = r;
    if (v && si < stim.size()) ib_in = stim[si].bus;
    else ib_in = '0;

    if (ob_out.tvalid && r && exp_out.size() > 0) begin
      total++;
      assert (ob_out === exp_out[0])
        else begin bad++; $error("FAIL ob_beat obs=%h exp=%h", ob_out, exp_out[0]); end
      $display("xfer out #%0d tlast=%0d tid=%0d tstrb=%h tuser=%h tdata=%h",
               n_out, ob_out.tlast, ob_out.tid, ob_out.tstrb, ob_out.tuser, ob_out.tdata);
      n_out++;
      void'(exp_out.pop_front());
    end

    ev_exp = 3'b000;
    if (ib_in.tvalid && ib_out.tready) begin
      s = stim[si];
      if (s.first) cur_drop = s.hdr_sot && s.is_ptype && cfg_en;
      if (!cur_drop) exp_out.push_back(s.bus);
      ev_exp = {s.ev2, s.lerr, cur_drop && s.bus.tlast};
      si++;
    end
  endtask

  // Run the queued stimulus to completion within a cycle budget.
  task automatic run(input int vmode, input int rmode, input int cmode, input int budget);
    int c = 0;
    while ((si < stim.size() || exp_out.size() != 0) && c < budget) begin
      cycle(vmode, rmode, cmode);
      c++;
    end
    total++;
    assert (c < budget)
      else begin bad++; $error("FAIL timeout cycles=%0d limit=%0d", c, budget); end
    cycle(0, 1, cmode);
    stim.delete();
    si = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    ib_in        = '0;
    ob_in.tready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    assert (ob_out === '0)
      else begin bad++; $error("FAIL rst_ob_out obs=%h exp=0", ob_out); end
    total++;
    assert (ib_out.tready === 1'b0)
      else begin bad++; $error("FAIL rst_tready obs=%b exp=0", ib_out.tready); end
    total++;
    assert (events === 3'b000)
      else begin bad++; $error("FAIL rst_events obs=%b exp=000", events); end
    rst = 1'b0;
    exp_out.delete();
    stim.delete();
    si        = 0;
    ev_exp    = 3'b000;
    cur_drop  = 1'b0;
    last_term = 1'b1;
  endtask

  initial begin
    bit         r_sot;
    bit         r_pfx;
    bit         r_term;
    int         r_n;
    int         r_hdr;
    logic [7:0] r_typ;

    rst          = 1'b1;
    ib_in        = '0;
    ob_in.tready = 1'b1;
    cfg_en       = 1'b0;

    // Reset values
    do_reset();

    // Passthrough: 3-beat type-1 TLV; the tight budget also catches stalls
    add_tlv(1, 8'd1, 3, 3, 1);
    run(1, 1, 1, 5);

    // Strip: 4-beat prefix, then a 2-beat type-1 TLV
    add_tlv(1, PTYPE, 4, 4, 1);
    add_tlv(1, 8'd1, 2, 2, 1);
    run(1, 1, 1, 20);

    // Strip disabled: the same stream is forwarded in full
    add_tlv(1, PTYPE, 4, 4, 1);
    add_tlv(1, 8'd1, 2, 2, 1);
    run(1, 1, 0, 20);

    // Enable toggling every cycle: only the value on the SOT beat matters
    add_tlv(1, PTYPE, 4, 4, 1);
    add_tlv(1, 8'd1, 2, 2, 1);
    add_tlv(1, PTYPE, 3, 3, 1);
    run(1, 1, 3, 30);

    // Length error: header says 5, tlast on beat 3
    add_tlv(1, 8'd1, 5, 3, 1);
    run(1, 1, 1, 20);

    // Backpressure: exactly two beats enter, then tready drops
    add_tlv(1, 8'd1, 5, 5, 1);
    for (int i = 0; i < 10; i++) cycle(1, 0, 1);
    total++;
    assert (si === 2)
      else begin bad++; $error("FAIL bp_accepted obs=%0d exp=2", si); end
    total++;
    assert (ib_out.tready === 1'b0)
      else begin bad++; $error("FAIL bp_tready obs=%b exp=0", ib_out.tready); end
    run(1, 1, 1, 40);

    // Protocol errors: a headerless beat in IDLE, and SOTs interrupting open TLVs
    add_tlv(0, 8'd1, 0, 2, 1);
    add_tlv(1, 8'd1, 4, 2, 0);
    add_tlv(1, PTYPE, 2, 2, 1);
    add_tlv(1, PTYPE, 3, 2, 0);
    add_tlv(1, 8'd1, 2, 2, 1);
    run(1, 1, 1, 40);

    // Reset in the middle of a prefix drop, then a normal TLV
    add_tlv(1, PTYPE, 6, 6, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1);
    do_reset();
    add_tlv(1, 8'd1, 3, 3, 1);
    run(1, 1, 1, 20);

    // Randomized TLV streams with random valid, ready and enable
    for (int batch = 0; batch < 30; batch++) begin
      for (int t = 0; t < 10; t++) begin
        r_sot  = !last_term ? 1'b1 : ($urandom_range(0, 9) != 0);
        r_pfx  = ($urandom_range(0, 2) == 0);
        r_term = ($urandom_range(0, 7) != 0);
        r_typ  = 8'($urandom_range(0, 255));
        if (r_pfx) r_typ = PTYPE;
        else if (r_typ == PTYPE) r_typ = 8'd1;
        r_n    = $urandom_range((r_pfx && r_term) ? 2 : 1, 6);
        r_hdr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : r_n;
        add_tlv(r_sot, r_typ, r_hdr, r_n, r_term);
      end
      run(2, 2, 2, 2000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
